pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register, the generalised successor of the fixed ID/EX register. It carries a control bundle, a plain payload and N forwardable operand lanes between any two pipeline stages. It adds what the fixed version lacks: a valid bit, stall (hold) with late-forward capture, flush with defined priority, a configurable bubble encoding, and saturating stall/bubble performance counters. It is instantiated for the IF/ID, ID/EX, EX/MEM and MEM/WB boundaries of the miniRV pipeline.

Parameters:
CTRL_W, 16, width of control bundle (rf_we, ram_we, alu_op, br_op, rf_wsel, is_load...)
CTRL_NOP, 16'h0070, control value written on bubble/flush/reset (br_op field = 3'b111, all others 0)
PAY_W, 64, width of non-forwardable payload (pc4, ext, wR...)
DATA_W, 32, operand lane width
N_OPND, 3, number of forwardable operand lanes (rD1, B, rD2)
CNT_W, 16, performance counter width

Ports:
cpu_clk  in  1  clock, all state on rising edge
cpu_rst  in  1  asynchronous active-high reset
stall  in  1  hold register contents this cycle
flush  in  1  kill contents (branch/jump redirect)
nop  in  1  insert bubble (load-use); upstream data still captured
valid_in  in  1  upstream slot holds a real instruction
ctrl_in  in  CTRL_W  control bundle from upstream stage
pay_in  in  PAY_W  payload from upstream stage
opnd_in  in  N_OPND*DATA_W  operand lanes, lane i at [i*DATA_W +: DATA_W]
fwd_en  in  N_OPND  per-lane forward select
fwd_data  in  N_OPND*DATA_W  per-lane forwarded value
cnt_clr  in  1  synchronous clear of both counters
valid_out  out  1  slot holds a real instruction
ctrl_out  out  CTRL_W  registered control
pay_out  out  PAY_W  registered payload
opnd_out  out  N_OPND*DATA_W  registered operands
stall_cnt  out  CNT_W  cycles spent stalled
bubble_cnt  out  CNT_W  bubbles inserted

Behaviour:
- Reset (async, any time, incl. mid-stall): valid_out=0, ctrl_out=CTRL_NOP, pay_out=0, opnd_out=0, stall_cnt=0, bubble_cnt=0. Outputs change on cpu_rst assertion, independent of cpu_clk.
- Latency: 1 cycle; all outputs are registered.
- Per-edge priority: flush > stall > nop > normal load.
- flush: valid_out<=0, ctrl_out<=CTRL_NOP; pay_out/opnd_out load from inputs (value don't-care but deterministic). Overrides a simultaneous stall.
- stall (flush=0): valid_out, ctrl_out, pay_out hold. For each lane i, if fwd_en[i]=1 then opnd_out[i]<=fwd_data[i] (late-forward capture); otherwise it holds. nop is ignored while stalled.
- nop (no flush/stall): valid_out<=0, ctrl_out<=CTRL_NOP; pay_out and opnd_out load normally, with forwarding applied.
- Normal load: valid_out<=valid_in, ctrl_out<=ctrl_in, pay_out<=pay_in, opnd_out[i]<=fwd_en[i]?fwd_data[i]:opnd_in[i].
- ctrl_out is forced to CTRL_NOP whenever a bubble is written. Downstream logic treats valid_out=0 as a retired-nothing slot (trace inst_valid).
- stall_cnt: +1 on each edge with stall=1 and flush=0.
- bubble_cnt: +1 on each edge with flush=1, or with nop=1 and stall=0.
- Both counters saturate at all-ones and do not wrap.
- cnt_clr=1 forces both counters to 0 and wins over a same-cycle increment.
- No combinational path from any input to any output.

Decomposition:
- Shared package pipe_pkg: CTRL_W, the control field offsets (RF_WE, RAM_WE, ALU_OP, BR_OP, RF_WSEL, IS_LOAD), CTRL_NOP, BR_NONE=3'b111, DATA_W.
- One natural sub-module: sat_counter (parameter W; ports inc, clr, count), instantiated twice.
- The lane datapath is a generate loop over N_OPND with no further sub-module.

Test Plan:
1. Assert cpu_rst between clock edges while valid_out=1 and stall_cnt=5 -> all outputs reset immediately; ctrl_out=16'h0070, counters 0.
2. Normal load: valid_in=1, ctrl_in=16'h0123, opnd lane1=32'hAAAA_0001, fwd_en=3'b010, fwd lane1=32'h1234_5678 -> next cycle valid_out=1, ctrl_out=16'h0123, lane1=32'h1234_5678, lanes 0/2 = opnd_in.
3. Stall 3 cycles holding ctrl 16'h0123, with fwd_en[0]=1 and fwd_data=32'hDEAD_BEEF in cycle 2 only -> ctrl/pay unchanged, lane0 becomes 32'hDEAD_BEEF and holds, stall_cnt=3.
4. nop=1 with valid_in=1, ctrl_in=16'h0123 -> valid_out=0, ctrl_out=16'h0070, pay_out=pay_in, bubble_cnt=1. Repeat with stall=1 -> register holds, bubble_cnt unchanged.
5. flush=1 and stall=1 together -> valid_out=0, ctrl_out=16'h0070, bubble_cnt +1, stall_cnt unchanged.
6. CNT_W=4, stall held 20 cycles -> stall_cnt saturates at 4'hF. Then cnt_clr=1 with stall=1 -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control bundle layout and the bubble encoding.
package pipe_pkg;
  localparam int CTRL_W = 16;
  localparam int DATA_W = 32;

  // Control field offsets (LSB of each field)
  localparam int RF_WE   = 0;
  localparam int RAM_WE  = 1;
  localparam int RF_WSEL = 2;   // 2 bits
  localparam int BR_OP   = 4;   // 3 bits
  localparam int ALU_OP  = 7;   // 4 bits
  localparam int IS_LOAD = 11;

  localparam logic [2:0] BR_NONE = 3'b111;
  localparam logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'({BR_NONE, 4'b0000});
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         cpu_clk,
  input  logic         cpu_rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst)                 count <= '0;
    else if (clr)                count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid bit, stall, flush, bubble
// insertion, late-forward capture on operand lanes and stall/bubble counters.
module pipe_stage_reg #(
  parameter int                CTRL_W   = pipe_pkg::CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(pipe_pkg::CTRL_NOP),
  parameter int                PAY_W    = 64,
  parameter int                DATA_W   = pipe_pkg::DATA_W,
  parameter int                N_OPND   = 3,
  parameter int                CNT_W    = 16
) (
  input  logic                     cpu_clk,
  input  logic                     cpu_rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     nop,
  input  logic                     valid_in,
  input  logic [CTRL_W-1:0]        ctrl_in,
  input  logic [PAY_W-1:0]         pay_in,
  input  logic [N_OPND*DATA_W-1:0] opnd_in,
  input  logic [N_OPND-1:0]        fwd_en,
  input  logic [N_OPND*DATA_W-1:0] fwd_data,
  input  logic                     cnt_clr,
  output logic                     valid_out,
  output logic [CTRL_W-1:0]        ctrl_out,
  output logic [PAY_W-1:0]         pay_out,
  output logic [N_OPND*DATA_W-1:0] opnd_out,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         bubble_cnt
);
  import pipe_pkg::*;

  logic stall_inc, bubble_inc;

  // Flush overrides stall; nop only counts when the register actually advances.
  assign stall_inc  = stall & ~flush;
  assign bubble_inc = flush | (nop & ~stall);

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      valid_out <= 1'b0;
      ctrl_out  <= CTRL_NOP;
      pay_out   <= '0;
    end else if (flush) begin
      valid_out <= 1'b0;
      ctrl_out  <= CTRL_NOP;
      pay_out   <= pay_in;
    end else if (!stall) begin
      valid_out <= valid_in & ~nop;
      ctrl_out  <= nop ? CTRL_NOP : ctrl_in;
      pay_out   <= pay_in;
    end
  end

  for (genvar i = 0; i < N_OPND; i++) begin : g_lane
    logic [DATA_W-1:0] fwd_lane, sel_lane, lane_q;

    assign fwd_lane = fwd_data[i*DATA_W +: DATA_W];
    assign sel_lane = fwd_en[i] ? fwd_lane : opnd_in[i*DATA_W +: DATA_W];

    // While stalled a lane still picks up a late-arriving forward value.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst)        lane_q <= '0;
      else if (flush)     lane_q <= sel_lane;
      else if (!stall)    lane_q <= sel_lane;
      else if (fwd_en[i]) lane_q <= fwd_lane;
    end

    assign opnd_out[i*DATA_W +: DATA_W] = lane_q;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .inc     (stall_inc),
    .clr     (cnt_clr),
    .count   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .inc     (bubble_inc),
    .clr     (cnt_clr),
    .count   (bubble_cnt)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed scenarios plus randomized traffic against a behavioural slot model.
module tb_pipe_stage_reg;
  localparam int CW = 16, PW = 64, DW = 32, NO = 3;
  localparam logic [CW-1:0] NOPC = 16'h0070;

  logic cpu_clk = 1'b0, cpu_rst = 1'b0;
  logic stall, flush, nop, valid_in, cnt_clr;
  logic [CW-1:0]    ctrl_in;
  logic [PW-1:0]    pay_in;
  logic [NO*DW-1:0] opnd_in, fwd_data;
  logic [NO-1:0]    fwd_en;

  logic valid_out, v4;
  logic [CW-1:0]    ctrl_out, c4;
  logic [PW-1:0]    pay_out, p4;
  logic [NO*DW-1:0] opnd_out, o4;
  logic [15:0]      stall_cnt, bubble_cnt;
  logic [3:0]       sc4, bc4;

  int errs = 0, checks = 0;

  // Model of the slot contents; lanes/payload become unknown after a flush.
  logic          m_valid;
  logic [CW-1:0] m_ctrl;
  logic [PW-1:0] m_pay;
  logic          m_pay_k;
  logic [DW-1:0] m_opnd [NO];
  logic          m_opnd_k [NO];
  int m_sc, m_bc, m_sc4, m_bc4;

  pipe_stage_reg dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .stall(stall), .flush(flush), .nop(nop),
    .valid_in(valid_in), .ctrl_in(ctrl_in), .pay_in(pay_in), .opnd_in(opnd_in),
    .fwd_en(fwd_en), .fwd_data(fwd_data), .cnt_clr(cnt_clr),
    .valid_out(valid_out), .ctrl_out(ctrl_out), .pay_out(pay_out), .opnd_out(opnd_out),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt));

  pipe_stage_reg #(.CNT_W(4)) dut4 (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .stall(stall), .flush(flush), .nop(nop),
    .valid_in(valid_in), .ctrl_in(ctrl_in), .pay_in(pay_in), .opnd_in(opnd_in),
    .fwd_en(fwd_en), .fwd_data(fwd_data), .cnt_clr(cnt_clr),
    .valid_out(v4), .ctrl_out(c4), .pay_out(p4), .opnd_out(o4),
    .stall_cnt(sc4), .bubble_cnt(bc4));

  always #5 cpu_clk = ~cpu_clk;

  function automatic logic [DW-1:0] lane(input logic [NO*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_ctrl = NOPC; m_pay = '0; m_pay_k = 1'b1;
    for (int i = 0; i < NO; i++) begin m_opnd[i] = '0; m_opnd_k[i] = 1'b1; end
    m_sc = 0; m_bc = 0; m_sc4 = 0; m_bc4 = 0;
  endtask

  task automatic model_edge();
    if (cnt_clr) begin
      m_sc = 0; m_bc = 0; m_sc4 = 0; m_bc4 = 0;
    end else begin
      if (stall && !flush) begin
        if (m_sc < 65535) m_sc++;
        if (m_sc4 < 15) m_sc4++;
      end
      if (flush || (nop && !stall)) begin
        if (m_bc < 65535) m_bc++;
        if (m_bc4 < 15) m_bc4++;
      end
    end
    if (flush) begin
      m_valid = 1'b0; m_ctrl = NOPC; m_pay_k = 1'b0;
      for (int i = 0; i < NO; i++) m_opnd_k[i] = 1'b0;
    end else if (stall) begin
      for (int i = 0; i < NO; i++)
        if (fwd_en[i]) begin m_opnd[i] = lane(fwd_data, i); m_opnd_k[i] = 1'b1; end
    end else begin
      m_valid = nop ? 1'b0 : valid_in;
      m_ctrl  = nop ? NOPC : ctrl_in;
      m_pay   = pay_in; m_pay_k = 1'b1;
      for (int i = 0; i < NO; i++) begin
        m_opnd[i]   = fwd_en[i] ? lane(fwd_data, i) : lane(opnd_in, i);
        m_opnd_k[i] = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    if (!cpu_rst) model_edge();
    @(negedge cpu_clk);
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; nop = 0; valid_in = 0; cnt_clr = 0;
    ctrl_in = '0; pay_in = '0; opnd_in = '0; fwd_en = '0; fwd_data = '0;
  endtask

  task automatic rand_data();
    pay_in   = {$urandom, $urandom};
    opnd_in  = {$urandom, $urandom, $urandom};
    fwd_data = {$urandom, $urandom, $urandom};
  endtask

  task automatic test_reset();
    idle_inputs();
    cpu_rst = 1'b1;
    repeat (2) @(negedge cpu_clk);
    cpu_rst = 1'b0;
    model_reset();
    valid_in = 1; ctrl_in = 16'h0123; rand_data();
    step();
    stall = 1;
    repeat (5) step();
    checks++;
    if (valid_out !== 1'b1 || stall_cnt !== 16'd5) begin
      errs++; $display("FAIL pre_reset: valid=%b stall_cnt=%0d want valid=1 stall_cnt=5", valid_out, stall_cnt);
    end
    #2 cpu_rst = 1'b1;
    #1;
    checks++;
    if (valid_out !== 1'b0 || ctrl_out !== NOPC || pay_out !== '0 || opnd_out !== '0 ||
        stall_cnt !== '0 || bubble_cnt !== '0 || sc4 !== '0) begin
      errs++;
      $display("FAIL async_reset: valid=%b ctrl=%h pay=%h opnd=%h sc=%0d bc=%0d want 0/0070/0/0/0/0",
               valid_out, ctrl_out, pay_out, opnd_out, stall_cnt, bubble_cnt);
    end
    @(negedge cpu_clk);
    idle_inputs();
    cpu_rst = 1'b0;
    model_reset();
  endtask

  logic [PW-1:0]    t2_pay;
  logic [NO*DW-1:0] t2_opnd;

  task automatic test_load();
    valid_in = 1; ctrl_in = 16'h0123; rand_data();
    opnd_in[DW +: DW] = 32'hAAAA_0001; fwd_data[DW +: DW] = 32'h1234_5678; fwd_en = 3'b010;
    t2_pay = pay_in; t2_opnd = opnd_in;
    step();
    checks++;
    if (valid_out !== 1'b1 || ctrl_out !== 16'h0123 || pay_out !== t2_pay) begin
      errs++; $display("FAIL load_ctrl: valid=%b ctrl=%h pay=%h want 1/0123/%h", valid_out, ctrl_out, pay_out, t2_pay);
    end
    checks++;
    if (lane(opnd_out, 0) !== lane(t2_opnd, 0) || lane(opnd_out, 1) !== 32'h1234_5678 ||
        lane(opnd_out, 2) !== lane(t2_opnd, 2)) begin
      errs++; $display("FAIL load_lanes: got %h want %h_12345678_%h", opnd_out, lane(t2_opnd, 2), lane(t2_opnd, 0));
    end
  endtask

  task automatic test_stall();
    stall = 1; valid_in = 0; ctrl_in = 16'hBEEF; rand_data(); fwd_en = 3'b000;
    step();
    rand_data(); fwd_en = 3'b001; fwd_data[0 +: DW] = 32'hDEAD_BEEF;
    step();
    rand_data(); fwd_en = 3'b000;
    step();
    checks++;
    if (valid_out !== 1'b1 || ctrl_out !== 16'h0123 || pay_out !== t2_pay) begin
      errs++; $display("FAIL stall_hold: valid=%b ctrl=%h pay=%h want 1/0123/%h", valid_out, ctrl_out, pay_out, t2_pay);
    end
    checks++;
    if (lane(opnd_out, 0) !== 32'hDEAD_BEEF || lane(opnd_out, 1) !== 32'h1234_5678 ||
        lane(opnd_out, 2) !== lane(t2_opnd, 2)) begin
      errs++; $display("FAIL stall_fwd: got %h want %h_12345678_deadbeef", opnd_out, lane(t2_opnd, 2));
    end
    checks++;
    if (stall_cnt !== 16'd3 || bubble_cnt !== 16'd0) begin
      errs++; $display("FAIL stall_cnt: sc=%0d bc=%0d want 3/0", stall_cnt, bubble_cnt);
    end
  endtask

  task automatic test_nop();
    logic [PW-1:0] p;
    stall = 0; nop = 1; valid_in = 1; ctrl_in = 16'h0123; rand_data(); fwd_en = 3'b000;
    p = pay_in;
    step();
    checks++;
    if (valid_out !== 1'b0 || ctrl_out !== NOPC || pay_out !== p || opnd_out !== opnd_in || bubble_cnt !== 16'd1) begin
      errs++; $display("FAIL nop_bubble: valid=%b ctrl=%h pay=%h bc=%0d want 0/0070/%h/1", valid_out, ctrl_out, pay_out, bubble_cnt, p);
    end
    stall = 1; rand_data();
    step();
    checks++;
    if (valid_out !== 1'b0 || ctrl_out !== NOPC || pay_out !== p || bubble_cnt !== 16'd1 || stall_cnt !== 16'd4) begin
      errs++; $display("FAIL nop_stalled: valid=%b ctrl=%h pay=%h bc=%0d sc=%0d want 0/0070/%h/1/4", valid_out, ctrl_out, pay_out, bubble_cnt, stall_cnt, p);
    end
  endtask

  task automatic test_flush_stall();
    stall = 0; nop = 0; valid_in = 1; ctrl_in = 16'h0155; rand_data();
    step();
    checks++;
    if (valid_out !== 1'b1 || ctrl_out !== 16'h0155) begin
      errs++; $display("FAIL refill: valid=%b ctrl=%h want 1/0155", valid_out, ctrl_out);
    end
    flush = 1; stall = 1; rand_data();
    step();
    checks++;
    if (valid_out !== 1'b0 || ctrl_out !== NOPC || bubble_cnt !== 16'd2 || stall_cnt !== 16'd4) begin
      errs++; $display("FAIL flush_over_stall: valid=%b ctrl=%h bc=%0d sc=%0d want 0/0070/2/4", valid_out, ctrl_out, bubble_cnt, stall_cnt);
    end
    flush = 0; stall = 0;
  endtask

  task automatic test_saturate();
    stall = 1; valid_in = 0;
    repeat (20) step();
    checks++;
    if (sc4 !== 4'hF || stall_cnt !== 16'd24) begin
      errs++; $display("FAIL stall_sat: sc4=%h sc16=%0d want f/24", sc4, stall_cnt);
    end
    stall = 0; nop = 1;
    repeat (20) step();
    checks++;
    if (bc4 !== 4'hF || bubble_cnt !== 16'd22) begin
      errs++; $display("FAIL bubble_sat: bc4=%h bc16=%0d want f/22", bc4, bubble_cnt);
    end
    nop = 0; stall = 1; cnt_clr = 1;
    step();
    checks++;
    if (sc4 !== 4'h0 || bc4 !== 4'h0 || stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
      errs++; $display("FAIL cnt_clr: sc4=%h bc4=%h sc=%0d bc=%0d want all 0", sc4, bc4, stall_cnt, bubble_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      stall    = ($urandom_range(99) < 30);
      flush    = ($urandom_range(99) < 10);
      nop      = ($urandom_range(99) < 15);
      cnt_clr  = ($urandom_range(99) < 3);
      valid_in = $urandom_range(1);
      ctrl_in  = 16'($urandom);
      fwd_en   = 3'($urandom);
      rand_data();
      step();
      checks++;
      if (valid_out !== m_valid || ctrl_out !== m_ctrl || v4 !== m_valid || c4 !== m_ctrl) begin
        errs++; $display("FAIL rnd_ctrl[%0d]: valid=%b ctrl=%h want %b/%h", n, valid_out, ctrl_out, m_valid, m_ctrl);
      end
      if (m_pay_k) begin
        checks++;
        if (pay_out !== m_pay) begin
          errs++; $display("FAIL rnd_pay[%0d]: got %h want %h", n, pay_out, m_pay);
        end
      end
      for (int i = 0; i < NO; i++) if (m_opnd_k[i]) begin
        checks++;
        if (lane(opnd_out, i) !== m_opnd[i]) begin
          errs++; $display("FAIL rnd_lane%0d[%0d]: got %h want %h", i, n, lane(opnd_out, i), m_opnd[i]);
        end
      end
      checks++;
      if (int'(stall_cnt) != m_sc || int'(bubble_cnt) != m_bc || int'(sc4) != m_sc4 || int'(bc4) != m_bc4) begin
        errs++; $display("FAIL rnd_cnt[%0d]: sc=%0d bc=%0d sc4=%0d bc4=%0d want %0d/%0d/%0d/%0d",
                         n, stall_cnt, bubble_cnt, sc4, bc4, m_sc, m_bc, m_sc4, m_bc4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_nop();
    test_flush_stall();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
